// File: rtl/tx_share_arbiter.sv
// Round-robin sharing of one byte-serial transmitter among NREQ producers.
// Sequences load -> send -> wait-for-end per grant, aborting stalled transfers on timeout.
module tx_share_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 1200,
   parameter int CW      = 11
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic [NREQ-1:0]   req_i,
   input  logic [8*NREQ-1:0] req_data_i,
   output logic [NREQ-1:0]   gnt_o,
   output logic [NREQ-1:0]   done_o,
   output logic [NREQ-1:0]   err_o,
   input  logic              dsr_i,
   output logic              tx_load_o,
   output logic [7:0]        tx_data_o,
   output logic              tx_send_o,
   input  logic              tx_end_i,
   output logic              tx_abort_o,
   output logic [7:0]        err_cnt_o,
   output logic              busy_o
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [IW:0]   NREQ_W   = (IW+1)'(NREQ);
   localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);
   localparam logic [CW-1:0] TMAX     = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SEND_WAIT, S_WAIT_END, S_DONE, S_ABORT
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]   timer_q, timer_d;
   logic [7:0]      data_q, data_d;
   logic [7:0]      err_cnt_q, err_cnt_d;

   logic [NREQ-1:0] req_rot;
   logic [IW-1:0]   pick_off;
   logic [IW:0]     pick_sum;
   logic [IW-1:0]   pick;
   logic            any_req;
   logic [NREQ-1:0] onehot;
   logic [7:0]      sel_byte;
   logic [IW-1:0]   idx_next;
   logic            timeout;

   // Rotate requests so bit k corresponds to requester (rr_ptr + k) mod NREQ.
   assign req_rot = NREQ'({req_i, req_i} >> rr_ptr_q);

   always_comb begin
      pick_off = '0;
      any_req  = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            pick_off = IW'(k);
            any_req  = 1'b1;
         end
      end
   end

   assign pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
   assign pick     = (pick_sum >= NREQ_W) ? IW'(pick_sum - NREQ_W) : pick_sum[IW-1:0];
   assign idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
   assign onehot   = NREQ'(1) << idx_q;
   assign sel_byte = req_data_i[{idx_q, 3'b000} +: 8];
   assign timeout  = (timer_q == TMAX);

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         rr_ptr_q  <= '0;
         timer_q   <= '0;
         data_q    <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         rr_ptr_q  <= rr_ptr_d;
         timer_q   <= timer_d;
         data_q    <= data_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      rr_ptr_d  = rr_ptr_q;
      timer_d   = timer_q;
      data_d    = data_q;
      err_cnt_d = err_cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (any_req) begin
               idx_d   = pick;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            data_d  = sel_byte;
            timer_d = '0;
            state_d = S_SEND_WAIT;
         end
         // A dsr or tx_end arriving on the timeout cycle still wins.
         S_SEND_WAIT: begin
            if (dsr_i)        state_d = S_WAIT_END;
            else if (timeout) state_d = S_ABORT;
            else              timer_d = timer_q + CW'(1);
         end
         S_WAIT_END: begin
            if (tx_end_i)     state_d = S_DONE;
            else if (timeout) state_d = S_ABORT;
            else              timer_d = timer_q + CW'(1);
         end
         S_DONE: begin
            rr_ptr_d = idx_next;
            state_d  = S_IDLE;
         end
         S_ABORT: begin
            rr_ptr_d  = idx_next;
            err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign gnt_o      = (state_q != S_IDLE)  ? onehot : '0;
   assign done_o     = (state_q == S_DONE)  ? onehot : '0;
   assign err_o      = (state_q == S_ABORT) ? onehot : '0;
   assign tx_load_o  = (state_q == S_LOAD);
   assign tx_send_o  = (state_q == S_SEND_WAIT) && dsr_i;
   assign tx_abort_o = (state_q == S_ABORT);
   assign tx_data_o  = (state_q == S_LOAD) ? sel_byte : data_q;
   assign err_cnt_o  = err_cnt_q;
   assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_tx_share_arbiter.sv
// Randomized bench for tx_share_arbiter; expectations come from a transaction-level
// model that predicts grant index and event cycles arithmetically.
module tb_tx_share_arbiter;

   localparam int N = 4;
   localparam int T = 64;

   logic          clock = 1'b0;
   logic          reset;
   logic [N-1:0]  req;
   logic [8*N-1:0] req_data;
   logic [N-1:0]  gnt, done, err;
   logic          dsr, tx_load, tx_send, tx_end, tx_abort, busy;
   logic [7:0]    tx_data, err_cnt;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            rr_ptr_m = 0;
   int            errcnt_m = 0;
   logic [7:0]    last_byte_m = 8'h00;
   int            txn_no = 0;

   tx_share_arbiter #(.NREQ(N), .TIMEOUT(T), .CW(7)) dut (
      .clock_i    (clock),
      .reset_i    (reset),
      .req_i      (req),
      .req_data_i (req_data),
      .gnt_o      (gnt),
      .done_o     (done),
      .err_o      (err),
      .dsr_i      (dsr),
      .tx_load_o  (tx_load),
      .tx_data_o  (tx_data),
      .tx_send_o  (tx_send),
      .tx_end_i   (tx_end),
      .tx_abort_o (tx_abort),
      .err_cnt_o  (err_cnt),
      .busy_o     (busy)
   );

   always #5 clock = ~clock;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic int pick_model(input logic [N-1:0] r, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (r[(ptr + k) % N]) return (ptr + k) % N;
      end
      return 0;
   endfunction

   function automatic logic [31:0] exp_vec(input logic [N-1:0] g, input logic [N-1:0] dn,
                                           input logic [N-1:0] er, input logic ld, input logic sd,
                                           input logic ab, input logic bz, input logic [7:0] dat);
      return {8'h00, g, dn, er, ld, sd, ab, bz, dat};
   endfunction

   function automatic logic [31:0] obs_vec();
      return {8'h00, gnt, done, err, tx_load, tx_send, tx_abort, busy, tx_data};
   endfunction

   task automatic next_cycle();
      @(posedge clock);
      #2;
   endtask

   task automatic idle_check(input string tag);
      #1;
      check_val(tag, obs_vec(), exp_vec('0, '0, '0, 0, 0, 0, 0, last_byte_m));
      check_val({tag, "_errcnt"}, {24'h0, err_cnt}, errcnt_m);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         req    = '0;
         dsr    = 1'($urandom_range(0, 1));
         tx_end = 1'($urandom_range(0, 1));
         idle_check($sformatf("idle_gap%0d", txn_no));
         next_cycle();
      end
   endtask

   // Entered at an IDLE cycle; returns at the IDLE cycle following DONE/ABORT.
   // d = cycles of dsr low after LOAD, e = cycles from tx_send to tx_end.
   task automatic run_txn(input logic [N-1:0] r, input logic [31:0] rd, input int d,
                          input int e, input bit drop, input bit noise);
      int idx, send_c, end_c, fin_c, noise_lim;
      bit ok;
      logic [N-1:0] oh;
      logic [7:0] b;
      idx = pick_model(r, rr_ptr_m);
      oh  = N'(1) << idx;
      b   = rd[8*idx +: 8];
      send_c = -1;
      end_c  = -1;
      if (d >= T) begin
         ok = 0; fin_c = T + 2; noise_lim = fin_c - 1;
      end else begin
         send_c = 2 + d;
         noise_lim = send_c;
         if (d + e <= T) begin
            ok = 1; end_c = send_c + e; fin_c = end_c + 1;
         end else begin
            ok = 0; fin_c = T + 3;
         end
      end
      req = r; req_data = rd; dsr = 1'b0; tx_end = 1'b0;
      idle_check($sformatf("txn%0d_idle", txn_no));
      for (int c = 1; c <= fin_c; c++) begin
         next_cycle();
         if (drop && c >= 2) req = '0;
         dsr    = (c >= 2 + d);
         tx_end = (ok && c == end_c) ||
                  (noise && c <= noise_lim && $urandom_range(0, 5) == 0);
         #1;
         check_val($sformatf("txn%0d_c%0d", txn_no, c), obs_vec(),
                   exp_vec(oh, (ok && c == fin_c) ? oh : '0, (!ok && c == fin_c) ? oh : '0,
                           c == 1, c == send_c, !ok && c == fin_c, 1'b1, b));
      end
      $display("txn %0d: req=%b idx=%0d data=%02h d=%0d e=%0d -> %s at c%0d",
               txn_no, r, idx, b, d, e, ok ? "done" : "abort", fin_c);
      next_cycle();
      rr_ptr_m    = (idx + 1) % N;
      errcnt_m    = ok ? errcnt_m : ((errcnt_m >= 255) ? 255 : errcnt_m + 1);
      last_byte_m = b;
      txn_no++;
   endtask

   initial begin
      reset = 1'b1; req = '0; req_data = '0; dsr = 1'b0; tx_end = 1'b0;
      #1;
      check_val("reset_outputs", obs_vec(), exp_vec('0, '0, '0, 0, 0, 0, 0, 8'h00));
      check_val("reset_errcnt", {24'h0, err_cnt}, 0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      next_cycle();

      // Round-robin with all requesters held.
      for (int i = 0; i < 5; i++)
         run_txn(4'b1111, $urandom, 0, $urandom_range(1, 6), 0, 0);

      // Single request, directed byte.
      run_txn(4'b0001, 32'h0000_00A5, 0, 20, 0, 0);
      idle_cycles(1);

      // dsr hold-off.
      run_txn(4'b0010, $urandom, 50, 5, 0, 1);

      // Timeout in WAIT_END, then next requester in turn.
      run_txn(4'b1111, $urandom, 0, 1000, 0, 0);
      check_val("errcnt_after_timeout", {24'h0, err_cnt}, 1);
      run_txn(4'b1111, $urandom, 0, 3, 0, 0);

      // tx_end exactly on the timeout cycle.
      run_txn(4'b0100, $urandom, 10, T - 10, 0, 0);
      run_txn(4'b1000, $urandom, 0, T, 0, 0);
      check_val("errcnt_after_tie", {24'h0, err_cnt}, 1);

      // Random mix.
      for (int i = 0; i < 60; i++) begin
         run_txn(N'($urandom_range(1, (1 << N) - 1)), $urandom,
                 ($urandom_range(0, 3) == 0) ? $urandom_range(55, 70) : $urandom_range(0, 6),
                 $urandom_range(1, 70), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         idle_cycles($urandom_range(0, 2));
      end

      // Error counter saturation.
      for (int i = 0; i < 300; i++)
         run_txn(4'b1111, $urandom, T, 1, 0, 0);
      check_val("errcnt_saturated", {24'h0, err_cnt}, 255);

      // Asynchronous reset while in WAIT_END.
      req = 4'b0010; req_data = $urandom; dsr = 1'b1; tx_end = 1'b0;
      next_cycle();
      next_cycle();
      next_cycle();
      next_cycle();
      #1;
      check_val("pre_reset_busy", {31'h0, busy}, 1);
      reset = 1'b1;
      #3;
      check_val("async_reset_outputs", obs_vec(), exp_vec('0, '0, '0, 0, 0, 0, 0, 8'h00));
      check_val("async_reset_errcnt", {24'h0, err_cnt}, 0);
      $display("async reset applied mid-transfer");
      req = '0; dsr = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      next_cycle();
      rr_ptr_m = 0; errcnt_m = 0; last_byte_m = 8'h00;
      run_txn(4'b0100, $urandom, 0, 4, 0, 0);
      idle_cycles(2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
